// File: rtl/vector_loader.sv
// Assembles four consecutive lane words into one vector and holds it until the consumer takes it.
// Two-state FSM: FILL collects lanes in ascending order, FULL presents the vector.
module vector_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             flush,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic [WIDTH-1:0] data_out4,
  output logic [2:0]       lane_count
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state_r;
  logic   accept_s;
  logic   release_s;
  logic   last_lane_s;

  // Handshake decode: a flush in the same cycle discards the presented word.
  always_comb begin
    accept_s    = 1'b0;
    release_s   = 1'b0;
    last_lane_s = 1'b0;
    if (state_r == FILL) begin
      accept_s    = word_valid && word_ready && !flush;
      last_lane_s = (lane_count == 3'd3);
    end else begin
      release_s   = vec_valid && vec_ready;
    end
  end

  // FSM, lane registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      lane_count <= 3'd0;
      vec_valid  <= 1'b0;
      word_ready <= 1'b1;
      data_out1  <= '0;
      data_out2  <= '0;
      data_out3  <= '0;
      data_out4  <= '0;
    end else begin
      case (state_r)
        FILL: begin
          if (flush) begin
            lane_count <= 3'd0;
          end else if (accept_s) begin
            case (lane_count)
              3'd0:    data_out1 <= word_in;
              3'd1:    data_out2 <= word_in;
              3'd2:    data_out3 <= word_in;
              3'd3:    data_out4 <= word_in;
              default: data_out4 <= data_out4;
            endcase
            lane_count <= lane_count + 3'd1;
            if (last_lane_s) begin
              state_r    <= FULL;
              vec_valid  <= 1'b1;
              word_ready <= 1'b0;
            end
          end
        end
        FULL: begin
          // Only the consumer can release a presented vector; lane data stays put.
          if (release_s) begin
            state_r    <= FILL;
            lane_count <= 3'd0;
            vec_valid  <= 1'b0;
            word_ready <= 1'b1;
          end
        end
        default: begin
          state_r    <= FILL;
          lane_count <= 3'd0;
          vec_valid  <= 1'b0;
          word_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
